// File: rtl/dl_mem_writer.sv
// Download write stage: buffers byte strobes in a FIFO, commits them through a req/ack memory port,
// then holds the CPU and issues a post-load cold reset. Optional byte checksum under DL_CHECKSUM_EN.
module dl_mem_writer #(
    parameter int DEPTH     = 8,
    parameter int RESET_LEN = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dl_wr,
    input  logic [24:0] dl_addr,
    input  logic [7:0]  dl_data,
    input  logic        dl_downloading,
    input  logic [4:0]  dl_index,
    output logic        mem_req,
    output logic [24:0] mem_addr,
    output logic [7:0]  mem_din,
    input  logic        mem_ack,
    output logic        cpu_hold,
    output logic        dl_done,
    output logic [4:0]  done_index,
    output logic        cold_reset,
    output logic        overflow
`ifdef DL_CHECKSUM_EN
   ,output logic [15:0] checksum
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int RW = $clog2(RESET_LEN + 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_GAP} state_t;

    state_t          r_state, w_state_next;
    logic [1:0]      r_sync;
    logic            w_dls, w_dls_rise, w_dls_fall;
    logic [32:0]     r_fifo [DEPTH];
    logic [PW-1:0]   r_wptr, r_rptr;
    logic [CW-1:0]   r_count;
    logic            w_empty, w_full, w_push, w_pop, w_busy;
    logic [24:0]     r_mem_addr;
    logic [7:0]      r_mem_din;
    logic            r_pending, r_dl_done, r_overflow;
    logic [4:0]      r_done_index;
    logic [RW-1:0]   r_rst_cnt;

    // Edges are taken across the second sync stage so pending arms on the same edge dls falls.
    assign w_dls      = r_sync[1];
    assign w_dls_rise =  r_sync[0] & ~r_sync[1];
    assign w_dls_fall = ~r_sync[0] &  r_sync[1];

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_push  = dl_wr & (~w_full | w_pop);
    assign w_busy  = (r_state != S_IDLE) | ~w_empty;

    always_ff @(posedge clk) begin
        if (w_push)
            r_fifo[r_wptr] <= {dl_addr, dl_data};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync     <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_state    <= S_IDLE;
            r_mem_addr <= '0;
            r_mem_din  <= '0;
        end else begin
            r_sync  <= {r_sync[0], dl_downloading};
            r_state <= w_state_next;
            if (w_push)
                r_wptr <= r_wptr + 1'b1;
            if (w_pop) begin
                r_rptr                  <= r_rptr + 1'b1;
                {r_mem_addr, r_mem_din} <= r_fifo[r_rptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE: if (!w_empty) begin
                w_pop        = 1'b1;
                w_state_next = S_REQ;
            end
            S_REQ:   if (mem_ack) w_state_next = S_GAP;
            S_GAP:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending    <= 1'b0;
            r_dl_done    <= 1'b0;
            r_rst_cnt    <= '0;
            r_done_index <= '0;
            r_overflow   <= 1'b0;
        end else begin
            r_dl_done <= 1'b0;
            if (r_rst_cnt != '0)
                r_rst_cnt <= r_rst_cnt - 1'b1;
            if (w_dls_fall)
                r_pending <= 1'b1;
            if (r_pending && !w_busy) begin
                r_dl_done <= 1'b1;
                r_rst_cnt <= RW'(RESET_LEN);
                r_pending <= 1'b0;
            end
            // A new download start overrides any completion in flight.
            if (w_dls_rise) begin
                r_pending    <= 1'b0;
                r_rst_cnt    <= '0;
                r_done_index <= dl_index;
                r_overflow   <= 1'b0;
            end
            if (dl_wr && !w_push)
                r_overflow <= 1'b1;
        end
    end

`ifdef DL_CHECKSUM_EN
    logic [15:0] r_checksum;

    always_ff @(posedge clk) begin
        if (reset)
            r_checksum <= '0;
        else
            r_checksum <= (w_dls_rise ? 16'h0000 : r_checksum) + (w_push ? {8'h00, dl_data} : 16'h0000);
    end

    assign checksum = r_checksum;
`endif

    assign mem_req    = (r_state == S_REQ);
    assign mem_addr   = r_mem_addr;
    assign mem_din    = r_mem_din;
    assign dl_done    = r_dl_done;
    assign done_index = r_done_index;
    assign cold_reset = (r_rst_cnt != '0);
    assign overflow   = r_overflow;
    assign cpu_hold   = w_dls | w_busy | r_pending | cold_reset;

endmodule
